reg_file_mp: RTL and testbench

- Parametrised successor to the single-port accumulator register file; sits between the decode/ALU stage and write-back in the core.
- Depth 2**PW, data width DW, NRD combinational read ports.
- Register 0 is the accumulator. Register 2**PW-1 is the status register, holding FW flag bits.
- Adds an explicit flag write enable, a multi-cycle clear sequencer with a busy indication, and a sticky lost-write indicator.

---
 rtl/reg_file_mp_pkg.sv | 22 ++
 rtl/reg_file_mp_if.sv | 53 +++++
 rtl/reg_file_mp_clear_seq.sv | 75 +++++++
 rtl/reg_file_mp.sv | 104 ++++++++++
 tb/tb_reg_file_mp.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared types and constants for the multi-port accumulator register file.
//   rf_state_e  : clear sequencer states (idle / clear sweep in progress)
//   ACC_IDX     : index of the accumulator register
//   status_idx  : index of the status register for a given pointer width
// ---------------------------------------------------------------------------
package reg_file_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int ACC_IDX = 0;

  // The status register always lives at the top of the array.
  function automatic int status_idx(input int pw);
    return (1 << pw) - 1;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if
// Bus between the decode/ALU stage (master) and the register file (slave).
//   wr_en/wr_addr/dat_in   : register write request
//   flag_we/flag_in        : status flag update request
//   clr_req                : start a clear sweep
//   rd_addr                : NRD read pointers
//   dat_out                : NRD read data words (combinational)
//   dat_acc_out            : accumulator (register 0)
//   dat_status_out         : status register flag bits
//   busy                   : clear sweep in progress
//   wr_lost                : sticky, a request was dropped while busy
//   dbg_state              : clear sequencer state, for observation only
//
// Request semantics: wr_en, flag_we and clr_req are single-cycle requests
// sampled on every rising clk edge; there is no ready back-pressure. A write
// or flag request sampled while busy=1 is discarded (and sets wr_lost); the
// master is expected to watch busy if it cares about the drop.
// ---------------------------------------------------------------------------
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PW  = 4,
  parameter int NRD = 2,
  parameter int FW  = 4
) ();

  logic                     wr_en;
  logic [PW-1:0]            wr_addr;
  logic [DW-1:0]            dat_in;
  logic                     flag_we;
  logic [FW-1:0]            flag_in;
  logic                     clr_req;
  logic [NRD-1:0][PW-1:0]   rd_addr;
  logic [NRD-1:0][DW-1:0]   dat_out;
  logic [DW-1:0]            dat_acc_out;
  logic [FW-1:0]            dat_status_out;
  logic                     busy;
  logic                     wr_lost;
  rf_state_e                dbg_state;

  modport master (
    output wr_en, wr_addr, dat_in, flag_we, flag_in, clr_req, rd_addr,
    input  dat_out, dat_acc_out, dat_status_out, busy, wr_lost, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, dat_in, flag_we, flag_in, clr_req, rd_addr,
    output dat_out, dat_acc_out, dat_status_out, busy, wr_lost, dbg_state
  );

endinterface

// File: rtl/reg_file_mp_clear_seq.sv
// ---------------------------------------------------------------------------
// rf_clear_seq
// Clear sweep sequencer: on an accepted clr_req it walks a pointer from 0 to
// 2**PW-1, asserting clr_we each cycle so the array zeroes one entry per edge.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_clr_req   : start request (ignored while a sweep is running)
//   o_busy      : sweep in progress
//   o_clr_we    : clear the entry at o_clr_ptr on this edge
//   o_clr_ptr   : entry being cleared
//   o_state     : current FSM state (observation)
// ---------------------------------------------------------------------------
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [PW-1:0] o_clr_ptr,
  output rf_state_e     o_state
);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RF_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_busy      = 1'b0;
    o_clr_we    = 1'b0;
    case (r_state)
      RF_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        o_busy   = 1'b1;
        o_clr_we = 1'b1;
        // Exact all-ones compare ends the sweep; the pointer never wraps.
        if (r_ptr == '1) begin
          w_state_nxt = RF_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + PW'(1);
        end
      end
      default: begin
        w_state_nxt = RF_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign o_clr_ptr = r_ptr;
  assign o_state   = r_state;

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised register file, depth 2**PW, width DW, NRD combinational read
// ports. Register 0 is the accumulator, register 2**PW-1 holds FW status
// flags. A clear sweep zeroes the array one entry per cycle; requests that
// arrive during the sweep are dropped and flagged on the sticky wr_lost.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : reg_file_mp_if.slave (see interface for signal list)
// Build option:
//   RF_BYPASS_EN : when defined, reads see same-cycle writes (write-through)
//                  on dat_out, dat_acc_out and dat_status_out.
// ---------------------------------------------------------------------------
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DW  = 8,
  parameter int PW  = 4,
  parameter int NRD = 2,
  parameter int FW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);

  localparam int            DEPTH       = 1 << PW;
  localparam logic [PW-1:0] ACC_ADDR    = PW'(ACC_IDX);
  localparam logic [PW-1:0] STATUS_ADDR = PW'(status_idx(PW));

  logic [DW-1:0]          r_core [DEPTH];
  logic                   r_wr_lost;

  logic                   w_busy;
  logic                   w_clr_we;
  logic [PW-1:0]          w_clr_ptr;
  rf_state_e              w_state;
  logic [DW-1:0]          w_flag_ext;
  logic                   w_wr_ok;
  logic                   w_flag_ok;
  logic [NRD-1:0][DW-1:0] w_rd;
  logic [DW-1:0]          w_acc;
  logic [FW-1:0]          w_status;

  rf_clear_seq #(.PW(PW)) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .i_clr_req (bus.clr_req),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_ptr (w_clr_ptr),
    .o_state   (w_state)
  );

  always_comb begin
    w_flag_ext          = '0;
    w_flag_ext[FW-1:0]  = bus.flag_in;
  end

  // Normal writes only in IDLE; an explicit write to the status register
  // takes priority over a flag update on the same edge.
  assign w_wr_ok   = bus.wr_en & ~w_busy;
  assign w_flag_ok = bus.flag_we & ~w_busy &
                     ~(bus.wr_en && (bus.wr_addr == STATUS_ADDR));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_core[i] <= '0;
      r_wr_lost <= 1'b0;
    end else begin
      if (w_clr_we) r_core[w_clr_ptr] <= '0;
      if (w_busy && (bus.wr_en || bus.flag_we)) r_wr_lost <= 1'b1;
      if (w_flag_ok) r_core[STATUS_ADDR] <= w_flag_ext;
      if (w_wr_ok)   r_core[bus.wr_addr]  <= bus.dat_in;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_rd[i] = r_core[bus.rd_addr[i]];
`ifdef RF_BYPASS_EN
      if (w_wr_ok && (bus.rd_addr[i] == bus.wr_addr))
        w_rd[i] = bus.dat_in;
      else if (w_flag_ok && (bus.rd_addr[i] == STATUS_ADDR))
        w_rd[i] = w_flag_ext;
`endif
    end
    w_acc    = r_core[ACC_ADDR];
    w_status = r_core[STATUS_ADDR][FW-1:0];
`ifdef RF_BYPASS_EN
    if (w_wr_ok && (bus.wr_addr == ACC_ADDR)) w_acc = bus.dat_in;
    if (w_wr_ok && (bus.wr_addr == STATUS_ADDR)) w_status = bus.dat_in[FW-1:0];
    else if (w_flag_ok) w_status = bus.flag_in;
`endif
  end

  assign bus.dat_out        = w_rd;
  assign bus.dat_acc_out    = w_acc;
  assign bus.dat_status_out = w_status;
  assign bus.busy           = w_busy;
  assign bus.wr_lost        = r_wr_lost;
  assign bus.dbg_state      = w_state;

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Directed bench for reg_file_mp. The driver changes inputs 1 time unit after
// each rising edge and pushes the values expected during that cycle; the
// monitor pops and compares them on the following falling edge.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW  = 8;
  localparam int PW  = 4;
  localparam int NRD = 2;
  localparam int FW  = 4;

  localparam int SEL_DOUT  = 0;
  localparam int SEL_ACC   = 1;
  localparam int SEL_STAT  = 2;
  localparam int SEL_BUSY  = 3;
  localparam int SEL_WLOST = 4;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DW(DW), .PW(PW), .NRD(NRD), .FW(FW)) bus ();

  reg_file_mp #(.DW(DW), .PW(PW), .NRD(NRD), .FW(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            sel_q[$];
  int            port_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic expect_val(input int sel, input int port, input logic [DW-1:0] v);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    port_q.push_back(port);
  endtask

  function automatic logic [DW-1:0] actual(input int sel, input int port);
    case (sel)
      SEL_DOUT:  return bus.dat_out[port];
      SEL_ACC:   return bus.dat_acc_out;
      SEL_STAT:  return DW'(bus.dat_status_out);
      SEL_BUSY:  return DW'(bus.busy);
      default:   return DW'(bus.wr_lost);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_DOUT:  return "dat_out";
      SEL_ACC:   return "dat_acc_out";
      SEL_STAT:  return "dat_status_out";
      SEL_BUSY:  return "busy";
      default:   return "wr_lost";
    endcase
  endfunction

  initial begin : monitor
    logic [DW-1:0] e;
    logic [DW-1:0] a;
    int            s;
    int            p;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        p = port_q.pop_front();
        a = actual(s, p);
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL %s[%0d] t=%0t: actual=%h expected=%h", sel_name(s), p, $time, a, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.flag_we = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic drive_wr(input int addr, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = PW'(addr);
    bus.dat_in  = d;
  endtask

  task automatic drive_flag(input logic [FW-1:0] f);
    bus.flag_we = 1'b1;
    bus.flag_in = f;
  endtask

  task automatic set_rd(input int p0, input int p1);
    bus.rd_addr[0] = PW'(p0);
    bus.rd_addr[1] = PW'(p1);
  endtask

  // Reads every address on both ports (in mirrored order on port 1),
  // starting in the current cycle; all must be zero.
  task automatic check_all_zero();
    for (int a = 0; a < 16; a++) begin
      if (a > 0) cyc();
      set_rd(a, 15 - a);
      expect_val(SEL_DOUT, 0, 8'h00);
      expect_val(SEL_DOUT, 1, 8'h00);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.dat_in  = '0;
    bus.flag_we = 1'b0;
    bus.flag_in = '0;
    bus.clr_req = 1'b0;
    bus.rd_addr = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    expect_val(SEL_BUSY,  0, 8'h00);
    expect_val(SEL_WLOST, 0, 8'h00);
    expect_val(SEL_ACC,   0, 8'h00);
    expect_val(SEL_STAT,  0, 8'h00);
    check_all_zero();

    // Plain writes, both ports on the same address, accumulator
    cyc(); drive_wr(3, 8'h5A);
    cyc(); set_rd(3, 3); drive_wr(0, 8'h11);
    expect_val(SEL_DOUT, 0, 8'h5A);
    expect_val(SEL_DOUT, 1, 8'h5A);
    cyc(); expect_val(SEL_ACC, 0, 8'h11);

    // Explicit status write beats flag_we on the same edge
    cyc(); drive_wr(15, 8'hC3); drive_flag(4'h6);
    cyc(); set_rd(15, 3);
    expect_val(SEL_DOUT, 0, 8'hC3);
    expect_val(SEL_STAT, 0, 8'h03);
    cyc(); drive_flag(4'h9);
    cyc(); expect_val(SEL_DOUT, 0, 8'h09); expect_val(SEL_STAT, 0, 8'h09);

    // Write elsewhere plus flag_we: both land
    cyc(); drive_wr(1, 8'h22); drive_flag(4'h5);
    cyc(); set_rd(1, 15);
    expect_val(SEL_DOUT, 0, 8'h22);
    expect_val(SEL_DOUT, 1, 8'h05);
    expect_val(SEL_STAT, 0, 8'h05);

    // Preload r0..r15 with 0x10+i, then sweep
    for (int i = 0; i < 16; i++) begin
      cyc(); drive_wr(i, 8'(8'h10 + i));
    end
    cyc(); bus.clr_req = 1'b1;
    expect_val(SEL_BUSY, 0, 8'h00);
    for (int j = 1; j <= 16; j++) begin
      cyc();
      set_rd(5, j - 1);
      expect_val(SEL_BUSY, 0, 8'h01);
      // r5 is zeroed by the 6th clearing edge
      expect_val(SEL_DOUT, 0, (j <= 6) ? 8'h15 : 8'h00);
      // the entry at the pointer still holds its old value this cycle
      expect_val(SEL_DOUT, 1, 8'(8'h10 + j - 1));
      expect_val(SEL_WLOST, 0, (j <= 10) ? 8'h00 : 8'h01);
      if (j == 8)  bus.clr_req = 1'b1;        // must not restart the sweep
      if (j == 10) drive_wr(2, 8'hAA);        // r2 already cleared; must stay 0
      if (j == 13) drive_flag(4'hF);
    end
    cyc();
    expect_val(SEL_BUSY,  0, 8'h00);
    expect_val(SEL_WLOST, 0, 8'h01);
    expect_val(SEL_STAT,  0, 8'h00);
    check_all_zero();
    cyc(); expect_val(SEL_WLOST, 0, 8'h01);

    // Reset in the middle of a sweep
    cyc(); drive_wr(4, 8'h44);
    cyc(); drive_wr(9, 8'h99);
    cyc(); bus.clr_req = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      cyc();
      expect_val(SEL_BUSY, 0, 8'h01);
      if (j == 7) reset = 1'b1;
    end
    cyc(); reset = 1'b0;
    expect_val(SEL_BUSY,  0, 8'h00);
    expect_val(SEL_WLOST, 0, 8'h00);
    check_all_zero();
    cyc(); drive_wr(9, 8'h3C);
    cyc(); set_rd(9, 9);
    expect_val(SEL_DOUT, 0, 8'h3C);
    expect_val(SEL_BUSY, 0, 8'h00);

    // Same-cycle visibility (write-through only with the bypass build)
    cyc(); drive_wr(4, 8'h55);
    cyc(); drive_wr(4, 8'h77); set_rd(4, 9);
    expect_val(SEL_DOUT, 0, BYP ? 8'h77 : 8'h55);
    expect_val(SEL_DOUT, 1, 8'h3C);
    cyc(); set_rd(4, 15); drive_flag(4'hA);
    expect_val(SEL_DOUT, 0, 8'h77);
    expect_val(SEL_DOUT, 1, BYP ? 8'h0A : 8'h00);
    expect_val(SEL_STAT, 0, BYP ? 8'h0A : 8'h00);
    cyc(); drive_wr(0, 8'h66);
    expect_val(SEL_ACC,  0, BYP ? 8'h66 : 8'h00);
    expect_val(SEL_DOUT, 1, 8'h0A);
    expect_val(SEL_STAT, 0, 8'h0A);
    cyc(); expect_val(SEL_ACC, 0, 8'h66);

    // Drain, bounded
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
